// File: rtl/inst_sequencer.sv
// Program memory plus fetch FSM that issues 16-bit instructions in address order
// on a valid/ready stream. Issuing stops at the HALT opcode or at the end of memory.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | presenting instructions to the core
// DONE  | program ended (HALT or end of memory), waiting for start
module inst_sequencer #(
    parameter int          AW      = 4,
    parameter logic [3:0]  HALT_OP = 4'he,
    parameter int          CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    output logic [15:0]   inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] issued
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** AW;

    state_t        state;
    logic [AW-1:0] pc;
    logic [15:0]   mem [DEPTH];

    // Program memory has no reset so the loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (prog_we && (state != RUN)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // pc starts at 1 after start, so pc == 0 while running means the word just
    // presented came from the last address and the program has run off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            inst       <= 16'h0000;
            inst_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            issued     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        issued <= '0;
                        pc     <= AW'(1);
                        if (mem[0][15:12] == HALT_OP) begin
                            state      <= DONE;
                            inst_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state      <= RUN;
                            inst       <= mem[0];
                            inst_valid <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (inst_valid && inst_ready) begin
                        if (issued != {CW{1'b1}}) begin
                            issued <= issued + CW'(1);
                        end
                        if ((pc == '0) || (mem[pc][15:12] == HALT_OP)) begin
                            state      <= DONE;
                            inst_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            inst <= mem[pc];
                            pc   <= pc + AW'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    inst_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: one task per scenario, inline comparisons
// against hand-computed instruction sequences.
module tb_inst_sequencer;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        busy;
    logic        done;
    logic [7:0]  issued;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [5];

    inst_sequencer #(.AW(4), .HALT_OP(4'he), .CW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .busy       (busy),
        .done       (done),
        .issued     (issued)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic load_basic();
        write_word(4'd0, 16'hf10a);
        write_word(4'd1, 16'hf202);
        write_word(4'd2, 16'h0112);
        write_word(4'd3, 16'hf203);
        write_word(4'd4, 16'h1112);
        write_word(4'd5, 16'he000);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs the basic program with ready high, checking every word and the end state.
    task automatic run_basic(input string tag);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== prog[i]) begin
                errors++;
                $display("FAIL %s word%0d: got valid=%b inst=%h, want valid=1 inst=%h",
                         tag, i, inst_valid, inst, prog[i]);
            end
            tick();
        end
        checks++;
        if (inst_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || issued !== 8'd5) begin
            errors++;
            $display("FAIL %s end: got valid=%b done=%b busy=%b issued=%0d, want 0 1 0 5",
                     tag, inst_valid, done, busy, issued);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (inst !== 16'h0000 || inst_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || issued !== 8'd0) begin
            errors++;
            $display("FAIL reset: got inst=%h valid=%b busy=%b done=%b issued=%0d, want 0000 0 0 0 0",
                     inst, inst_valid, busy, done, issued);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b busy=%b done=%b, want 0 0 0",
                     inst_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] r [16];
        logic [15:0] w;
        for (int i = 0; i < 16; i++) r[i] = 16'h0;
        load_basic();
        inst_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            w = inst;
            checks++;
            if (inst_valid !== 1'b1 || w !== prog[i]) begin
                errors++;
                $display("FAIL basic word%0d: got valid=%b inst=%h, want valid=1 inst=%h",
                         i, inst_valid, w, prog[i]);
            end
            case (w[15:12])
                4'hf:    r[w[11:8]] = {8'h00, w[7:0]};
                4'h0:    r[w[11:8]] = r[w[7:4]] + r[w[3:0]];
                4'h1:    r[w[11:8]] = r[w[7:4]] - r[w[3:0]];
                default: ;
            endcase
            tick();
        end
        checks++;
        if (inst_valid !== 1'b0 || done !== 1'b1 || issued !== 8'd5) begin
            errors++;
            $display("FAIL basic end: got valid=%b done=%b issued=%0d, want 0 1 5",
                     inst_valid, done, issued);
        end
        checks++;
        if (r[1] !== 16'd9) begin
            errors++;
            $display("FAIL basic core_r1: got %0d, want 9", r[1]);
        end
    endtask

    task automatic test_backpressure();
        logic pat [8];
        logic [15:0] prev;
        logic pv, pr;
        int idx;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        idx = 0;
        pulse_start();
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            pr = pat[k % 8];
            inst_ready = pr;
            prev = inst;
            pv = inst_valid;
            tick();
            if (pv && pr) begin
                checks++;
                if (idx >= 5) begin
                    errors++;
                    $display("FAIL bp extra_word: got %h after 5 accepted", prev);
                end else if (prev !== prog[idx]) begin
                    errors++;
                    $display("FAIL bp order%0d: got %h, want %h", idx, prev, prog[idx]);
                end
                idx++;
            end else if (pv) begin
                checks++;
                if (inst !== prev || inst_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp hold: got valid=%b inst=%h, want valid=1 inst=%h",
                             inst_valid, inst, prev);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || idx != 5 || issued !== 8'd5) begin
            errors++;
            $display("FAIL bp end: got done=%b accepted=%0d issued=%0d, want 1 5 5",
                     done, idx, issued);
        end
        inst_ready = 1'b1;
    endtask

    task automatic test_halt0();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        write_word(4'd0, 16'he123);
        pulse_start();
        checks++;
        if (inst_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || issued !== 8'd0) begin
            errors++;
            $display("FAIL halt0: got valid=%b done=%b busy=%b issued=%0d, want 0 1 0 0",
                     inst_valid, done, busy, issued);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL halt0 hold: got valid=%b done=%b, want 0 1", inst_valid, done);
        end
    endtask

    task automatic test_full();
        for (int a = 0; a < 16; a++) write_word(4'(a), 16'hf100 + 16'(a));
        inst_ready = 1'b1;
        pulse_start();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 16'hf100 + 16'(a)) begin
                errors++;
                $display("FAIL full word%0d: got valid=%b inst=%h, want valid=1 inst=%h",
                         a, inst_valid, inst, 16'hf100 + 16'(a));
            end
            tick();
        end
        checks++;
        if (inst_valid !== 1'b0 || done !== 1'b1 || issued !== 8'd16) begin
            errors++;
            $display("FAIL full end: got valid=%b done=%b issued=%0d, want 0 1 16",
                     inst_valid, done, issued);
        end
        tick();
        tick();
        checks++;
        if (inst_valid !== 1'b0 || issued !== 8'd16) begin
            errors++;
            $display("FAIL full nowrap: got valid=%b issued=%0d, want 0 16", inst_valid, issued);
        end
    endtask

    task automatic test_write_start();
        load_basic();
        inst_ready = 1'b1;
        pulse_start();
        // write and start while running: both must be ignored
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = 16'he000;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        checks++;
        if (inst !== 16'hf202 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_ignore: got inst=%h busy=%b, want f202 1", inst, busy);
        end
        tick();
        checks++;
        if (inst !== 16'h0112 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL write_in_run: got valid=%b inst=%h, want 1 0112", inst_valid, inst);
        end
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || issued !== 8'd5) begin
            errors++;
            $display("FAIL wr end: got done=%b issued=%0d, want 1 5", done, issued);
        end
        pulse_start();
        checks++;
        if (issued !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got issued=%0d busy=%b, want 0 1", issued, busy);
        end
        run_basic("restart");
        // start and write to address 0 on the same edge: fetch sees the old word
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 16'hf1ff;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        checks++;
        if (inst !== 16'hf10a || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_wr fetch: got valid=%b inst=%h, want 1 f10a", inst_valid, inst);
        end
        for (int i = 0; i < 5; i++) tick();
        pulse_start();
        checks++;
        if (inst !== 16'hf1ff) begin
            errors++;
            $display("FAIL start_wr landed: got inst=%h, want f1ff", inst);
        end
        for (int i = 0; i < 5; i++) tick();
        write_word(4'd0, 16'hf10a);
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        checks++;
        if (inst !== 16'h0112 || issued !== 8'd2) begin
            errors++;
            $display("FAIL mid pre: got inst=%h issued=%0d, want 0112 2", inst, issued);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000 || busy !== 1'b0 || issued !== 8'd0) begin
            errors++;
            $display("FAIL mid async: got valid=%b inst=%h busy=%b issued=%0d, want 0 0000 0 0",
                     inst_valid, inst, busy, issued);
        end
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (inst_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid no_resume: got valid=%b busy=%b, want 0 0", inst_valid, busy);
        end
        pulse_start();
        run_basic("replay");
    endtask

    initial begin
        prog = '{16'hf10a, 16'hf202, 16'h0112, 16'hf203, 16'h1112};
        rst_n      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 4'd0;
        prog_data  = 16'h0000;
        start      = 1'b0;
        inst_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_halt0();
        test_full();
        test_write_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
